// File: rtl/cmos_clk_gen_pkg.sv
// Purpose : shared types and helpers for the multi-channel clock generator.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: ch_cfg_t per-channel config, clamp_cfg() accept-time clamp,
//           LOCK_W lock counter width. Config fields are CFG_W wide so the
//           struct can be shared by any DIV_W up to 32; unused upper bits
//           are always zero and fold away.
package cmos_clk_gen_pkg;

    localparam int CFG_W  = 32;
    localparam int LOCK_W = 8;

    typedef struct packed {
        logic [CFG_W-1:0] div;    // period in clk cycles (>= 2)
        logic [CFG_W-1:0] high;   // high time (1 .. div-1)
        logic [CFG_W-1:0] phase;  // counter start value (< div)
    } ch_cfg_t;

    // Force a request into a legal shape: div >= 2, 1 <= high <= div-1,
    // phase reduced modulo the effective divisor.
    function automatic ch_cfg_t clamp_cfg(input logic [CFG_W-1:0] div,
                                          input logic [CFG_W-1:0] high,
                                          input logic [CFG_W-1:0] phase);
        ch_cfg_t c;
        c.div  = (div < CFG_W'(2)) ? CFG_W'(2) : div;
        c.high = (high < CFG_W'(1)) ? CFG_W'(1) : high;
        if (c.high > c.div - CFG_W'(1)) begin
            c.high = c.div - CFG_W'(1);
        end
        c.phase = phase % c.div;
        return c;
    endfunction

endpackage

// File: rtl/cmos_clk_gen_ch.sv
// Purpose : one divided-clock channel: period counter, shadow config, lock.
// Latency : clk_out/tick/lock are one register stage after counter state.
// Backpr. : pending=1 while a shadow config waits for its apply point.
// Ports   : clk, rst_n (sync active-low), en, sync_all, cfg_we + cfg_in
//           (pre-clamped), pending, clk_out, tick, lock.
module cmos_clk_gen_ch
    import cmos_clk_gen_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int DEF_DIV      = 4,
    parameter int LOCK_PERIODS = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    sync_all,
    input  logic    cfg_we,
    input  ch_cfg_t cfg_in,
    output logic    pending,
    output logic    clk_out,
    output logic    tick,
    output logic    lock
);

    localparam ch_cfg_t RST_CFG = clamp_cfg(CFG_W'(DEF_DIV), CFG_W'(DEF_DIV / 2), '0);

    ch_cfg_t            act_q, act_d;
    ch_cfg_t            sh_q, sh_d;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [LOCK_W-1:0]  lcnt_q, lcnt_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               lock_q, lock_d;
    logic               wrap;
    logic               apply;

    always_comb begin
        wrap  = (CFG_W'(cnt_q) == act_q.div - CFG_W'(1));
        // An idle channel has no period to finish, so the shadow goes live
        // immediately; sync_all also acts as a period boundary.
        apply = pend_q && (wrap || !en || sync_all);

        act_d  = act_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        if (cfg_we) begin
            sh_d   = cfg_in;
            pend_d = 1'b1;
        end
        if (apply) begin
            act_d  = sh_q;
            pend_d = 1'b0;
        end

        // Start value comes from the config that will be live next cycle.
        if (!en || sync_all || apply) begin
            cnt_d = DIV_W'(act_d.phase);
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // Only wraps under the applied config count toward lock; the wrap
        // that retires a pending config belongs to the old one.
        lcnt_d = lcnt_q;
        if (!en || cfg_we) begin
            lcnt_d = '0;
        end else if (wrap && !pend_q && (lcnt_q < LOCK_W'(LOCK_PERIODS))) begin
            lcnt_d = lcnt_q + LOCK_W'(1);
        end

        clk_out_d = en && (CFG_W'(cnt_q) < act_q.high);
        tick_d    = en && (cnt_q == '0);
        lock_d    = en && (lcnt_d >= LOCK_W'(LOCK_PERIODS));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q     <= RST_CFG;
            sh_q      <= RST_CFG;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            act_q     <= act_d;
            sh_q      <= sh_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            lock_q    <= lock_d;
        end
    end

    assign pending = pend_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign lock    = lock_q;

endmodule

// File: rtl/cmos_clk_gen.sv
// Purpose : NCH-channel glitch-free clock/tick generator with run-time config.
// Latency : outputs registered, 1 stage from counter; config live in 1..div_old cycles.
// Backpr. : cfg_ready = !pending of the addressed channel (0 for out-of-range cfg_ch).
// Ports   : clk, rst_n, ch_en[NCH], sync_all, cfg_valid/cfg_ready, cfg_ch,
//           cfg_div, cfg_high, [cfg_phase], clk_out[NCH], tick[NCH], lock[NCH].
// Option  : CMOS_CLK_GEN_PHASE_EN adds cfg_phase (counter start value);
//           without it every channel starts its period at 0.
module cmos_clk_gen
    import cmos_clk_gen_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int DIV_W        = 16,
    parameter int DEF_DIV      = 4,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NCH-1:0]                       ch_en,
    input  logic                                 sync_all,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                     cfg_div,
    input  logic [DIV_W-1:0]                     cfg_high,
`ifdef CMOS_CLK_GEN_PHASE_EN
    input  logic [DIV_W-1:0]                     cfg_phase,
`endif
    output logic [NCH-1:0]                       clk_out,
    output logic [NCH-1:0]                       tick,
    output logic [NCH-1:0]                       lock
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] cfg_we;
    logic [CFG_W-1:0] phase_raw;
    ch_cfg_t        cfg_clamped;
    logic           sel_pending;

    always_comb begin
`ifdef CMOS_CLK_GEN_PHASE_EN
        phase_raw = CFG_W'(cfg_phase);
`else
        phase_raw = '0;
`endif
        // One shared clamp; only the addressed channel latches it.
        cfg_clamped = clamp_cfg(CFG_W'(cfg_div), CFG_W'(cfg_high), phase_raw);

        sel_pending = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (CFG_W'(cfg_ch) == CFG_W'(i)) begin
                sel_pending = pending[i];
            end
        end
        cfg_ready = (CFG_W'(cfg_ch) < CFG_W'(NCH)) && !sel_pending;

        cfg_we = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_we[i] = cfg_valid && cfg_ready && (CFG_W'(cfg_ch) == CFG_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        cmos_clk_gen_ch #(
            .DIV_W        (DIV_W),
            .DEF_DIV      (DEF_DIV),
            .LOCK_PERIODS (LOCK_PERIODS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (ch_en[g]),
            .sync_all (sync_all),
            .cfg_we   (cfg_we[g]),
            .cfg_in   (cfg_clamped),
            .pending  (pending[g]),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .lock     (lock[g])
        );
    end

endmodule

// File: doc/cmos_clk_gen.md
# cmos_clk_gen

Parametrised multi-channel clock generator for the camera/LCD pipeline. It produces NCH independent divided clocks and period ticks from one fabric clock. Each channel's divisor and duty can be reprogrammed at run time without glitches, and each channel has a PLL-style lock indicator. It sits after the fixed board PLL and feeds sensor XCLK, pixel-rate clock enables and LCD timing.

## Interface
Parameters:
- NCH, 2: number of output channels (1..8).
- DIV_W, 16: width of divisor and high-count fields.
- DEF_DIV, 4: divisor loaded at reset (≥2).
- LOCK_PERIODS, 4: complete periods after a config change before lock reasserts (1..255).

Ports:
- clk, input, 1: single fabric clock; all logic is on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- ch_en, input, NCH: per-channel run enable.
- sync_all, input, 1: restart all enabled channels at period start.
- cfg_valid, input, 1: configuration request.
- cfg_ready, output, 1: request accepted when cfg_valid && cfg_ready.
- cfg_ch, input, max(1,$clog2(NCH)): target channel.
- cfg_div, input, DIV_W: new divisor (period in clk cycles).
- cfg_high, input, DIV_W: new high-time in clk cycles.
- clk_out, output, NCH: registered divided clocks.
- tick, output, NCH: one-cycle pulse on the first cycle of each period.
- lock, output, NCH: channel running a stable configuration.

## Operation
- Each channel has an active register pair (div, high), a shadow pair, a pending flag, a period counter cnt (0..div-1) and a lock counter.
- Arithmetic rules at accept time:
  - div_eff = max(cfg_div, 2).
  - high_eff = min(max(cfg_high, 1), div_eff-1).
  - Clamped values are stored in the shadow registers.
- Output rules:
  - clk_out = 1 while cnt < high, otherwise 0.
  - tick = 1 when cnt == 0.
  - Both are registered from the same counter state, so they are mutually aligned.
- Counter wrap: cnt increments each cycle and wraps from div-1 to 0.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - On accept: the shadow registers load, pending is set and lock[cfg_ch] drops the next cycle.
- Apply:
  - When pending is set and cnt == div-1, the shadow is copied to active and pending clears.
  - The next cycle is cnt = 0 under the new values.
  - The current period always completes, so no runt pulses occur.
- Lock:
  - The lock counter clears on accept.
  - It increments on each wrap under the applied config.
  - lock sets when the count reaches LOCK_PERIODS. The count saturates there.
- Disabled channel (ch_en = 0):
  - cnt held at 0, clk_out = 0, tick = 0, lock = 0, lock counter cleared.
  - Config is still accepted. With the channel idle, the shadow applies at once (next cycle).
- Enable rising edge: the period starts the next cycle at cnt = 0.
- sync_all: on the next cycle every enabled channel has cnt = start value. Pending is applied at the same time if set. The lock counter is not cleared.
- Simultaneous events:
  - Accept on a channel whose apply happens that cycle is impossible, because cfg_ready is 0.
  - sync_all together with the wrap cycle loads the start value once.

## Timing
- Reset values:
  - clk_out = 0, tick = 0, lock = 0.
  - cnt = 0, pending = 0.
  - active/shadow = (DEF_DIV, DEF_DIV/2 clamped).
  - cfg_ready = 1.
- Reset is honoured mid-period and mid-pending; it drops all state.
- Start-up: the first tick comes 1 cycle after the first cycle with rst_n = 1 and ch_en = 1.
- clk_out/tick latency from counter state: 1 register stage, with no combinational path to the outputs.
- Config accept to new period start: between 1 and div_old cycles.
- lock reasserts LOCK_PERIODS × div_new cycles after the new period starts (±0).

## Configuration
- CMOS_CLK_GEN_PHASE_EN defined:
  - Adds input cfg_phase [DIV_W-1:0], latched into the shadow on accept.
  - On apply, enable or sync_all, cnt loads cfg_phase mod div (start value).
  - tick fires when cnt wraps to 0.
- CMOS_CLK_GEN_PHASE_EN undefined: no port; the start value is always 0.

## Structure
- Package cmos_clk_gen_pkg:
  - typedef of the per-channel config struct (div, high, phase).
  - Clamp function.
  - Lock counter width constant (8).
- Sub-module cmos_clk_gen_ch: one channel (counter, shadow, lock). The top module generates NCH instances and does the cfg_ch demux/mux.

## Test plan
- Reset then ch_en = 1, DEF_DIV = 4 -> clk_out pattern 1100 repeating, tick every 4 cycles, lock after 16 cycles.
- Config ch0 div = 5, high = 2 mid-period -> old period completes, then pattern 11000; lock drops the next cycle and reasserts after 20 cycles.
- cfg_div = 0, cfg_high = 9 -> clamped to div = 2, high = 1; pattern 10.
- Second cfg_valid while pending -> cfg_ready = 0 until the apply cycle; the request is accepted on the first cycle after apply.
- Two channels at div 3 and 6, assert sync_all -> both tick on the same cycle afterward; lock stays high.
- With the macro defined: div = 8, phase = 3 on ch1 with sync_all -> ch1 tick occurs 5 cycles after ch0 tick; with the macro undefined the ticks coincide.
